// File: rtl/regfile_pkg.sv
// Shared defaults, address type and packed-port slicing helper for the register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned NUM_REGS_DEF = 8;
    localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    // Widest packed port bus the slicing helper handles.
    localparam int unsigned SLICE_W = 64;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Returns field idx of a bus made of equal-width fields, zero-extended.
    function automatic logic [SLICE_W-1:0] port_slice(input logic [SLICE_W-1:0] vec,
                                                      input int unsigned       idx,
                                                      input int unsigned       width);
        logic [SLICE_W-1:0] mask;
        mask = (SLICE_W'(1) << width) - SLICE_W'(1);
        return (vec >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, reservation and read signals of the multi-port register file.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic                     we_a;
    logic [ADDR_W-1:0]        waddr_a;
    logic [DATA_W-1:0]        wdata_a;
    logic                     we_b;
    logic [ADDR_W-1:0]        waddr_b;
    logic [DATA_W-1:0]        wdata_b;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     wr_conflict;

    modport master (
        output we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, rsv_en, rsv_addr, raddr,
        input  rdata, rbusy, busy_vec, wr_conflict
    );

    modport slave (
        input  we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, rsv_en, rsv_addr, raddr,
        output rdata, rbusy, busy_vec, wr_conflict
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservation sets, a write clears, and per-read-port lookup.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_a,
    input  logic [ADDR_W-1:0]        clr_addr_a,
    input  logic                     clr_b,
    input  logic [ADDR_W-1:0]        clr_addr_b,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [NUM_RD-1:0]        rbusy
);

    logic [NUM_REGS-1:0] busy_q;

    // Reservation has priority over a same-cycle write to the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (set_en && (set_addr == ADDR_W'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if ((clr_a && (clr_addr_a == ADDR_W'(r))) ||
                             (clr_b && (clr_addr_b == ADDR_W'(r)))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // Busy lookup for each read address.
    always_comb begin
        rbusy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rbusy[i] = busy_q[ADDR_W'(port_slice(SLICE_W'(raddr), i, ADDR_W))];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, N read ports, optional bypass
// and zero register, with a busy scoreboard for decode-time reservations.
module regfile_mp import regfile_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic                     wr_conflict_q;
    logic                     same_addr;
    logic                     wr_a;
    logic                     wr_b;
    logic                     rsv_ok;
    logic [NUM_RD-1:0]        byp_hit;
    logic [NUM_RD-1:0]        sb_rbusy;
    logic [NUM_RD*DATA_W-1:0] rdata_c;

    // Effective writes: R0 is read-only when hard-wired, and B loses to A on a clash.
    assign same_addr = (bus.waddr_a == bus.waddr_b);
    assign wr_a      = bus.we_a && !((ZERO_REG != 0) && (bus.waddr_a == '0));
    assign wr_b      = bus.we_b && !((ZERO_REG != 0) && (bus.waddr_b == '0)) &&
                       !(bus.we_a && same_addr);
    assign rsv_ok    = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    // Data array and the one-cycle conflict flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            if (wr_a) begin
                regs_q[bus.waddr_a] <= bus.wdata_a;
            end
            if (wr_b) begin
                regs_q[bus.waddr_b] <= bus.wdata_b;
            end
            wr_conflict_q <= bus.we_a && bus.we_b && same_addr;
        end
    end

    // Read muxes with optional write-to-read forwarding; A is applied last so it wins.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        rdata_c = '0;
        byp_hit = '0;
        addr    = '0;
        val     = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            addr = ADDR_W'(port_slice(SLICE_W'(bus.raddr), i, ADDR_W));
            val  = regs_q[addr];
            if ((BYPASS != 0) && wr_b && (bus.waddr_b == addr)) begin
                val        = bus.wdata_b;
                byp_hit[i] = 1'b1;
            end
            if ((BYPASS != 0) && wr_a && (bus.waddr_a == addr)) begin
                val        = bus.wdata_a;
                byp_hit[i] = 1'b1;
            end
            if (!rst || ((ZERO_REG != 0) && (addr == '0))) begin
                val = '0;
            end
            rdata_c[i*DATA_W +: DATA_W] = val;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (rsv_ok),
        .set_addr   (bus.rsv_addr),
        .clr_a      (wr_a),
        .clr_addr_a (bus.waddr_a),
        .clr_b      (wr_b),
        .clr_addr_b (bus.waddr_b),
        .raddr      (bus.raddr),
        .busy_vec   (bus.busy_vec),
        .rbusy      (sb_rbusy)
    );

    // A forwarded read carries the value that retires the reservation, so it is not busy.
    assign bus.rdata       = rdata_c;
    assign bus.rbusy       = sb_rbusy & ~byp_hit;
    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the 8-bit CPU datapath.
- Successor to the fixed 8x8, 2-read/1-write file, generalised in width, depth and read-port count.
- Adds a second write port with fixed priority, optional write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard.
- Sits between decode (reads, reservations) and writeback (ALU on port A, load unit on port B).

Parameters:
- DATA_W, 8: register width in bits.
- NUM_REGS, 8: register count; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS): address width (derived).
- NUM_RD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a read of a register being written this cycle returns the write data.
- ZERO_REG, 0: 1 = R0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- we_a  in  1  write enable, port A (higher priority).
- waddr_a  in  ADDR_W  write address, port A.
- wdata_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B.
- waddr_b  in  ADDR_W  write address, port B.
- wdata_b  in  DATA_W  write data, port B.
- rsv_en  in  1  mark rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data, packed the same way.
- rbusy  out  NUM_RD  busy bit of each read address.
- busy_vec  out  NUM_REGS  full scoreboard.
- wr_conflict  out  1  registered; set for one cycle after A and B wrote the same register.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers, busy bits and wr_conflict are cleared to 0 immediately.
  - rdata reads 0 and rbusy reads 0 throughout reset.
  - Writes and reservations are ignored while rst=0.
  - A reset asserted mid-write discards that write.
- Writes (rising edge of clk):
  - Register waddr_a takes wdata_a when we_a=1.
  - Register waddr_b takes wdata_b when we_b=1.
  - Different addresses: both writes land.
  - Same address: A wins, B is dropped, and wr_conflict=1 on the next cycle only.
- Reads: combinational, zero-latency, from the current register contents.
- Bypass (BYPASS=1):
  - If raddr_i matches an enabled write address, rdata_i = that write data.
  - A takes precedence over B.
  - rbusy_i for that port reads 0 in that cycle.
- BYPASS=0: reads return the pre-edge value; the new value is visible the cycle after the write.
- ZERO_REG=1:
  - Any read of address 0 returns 0 and rbusy reads 0, regardless of bypass.
  - Writes and reservations to R0 are ignored.
- Scoreboard, per register r, next-cycle busy:
  - Set when rsv_en=1 and rsv_addr=r; reservation wins over a same-cycle write to r.
  - Otherwise cleared when either write port writes r.
  - Otherwise held.
- Reservation of an already-busy register: busy stays 1, no error.
- A write to a non-busy register is legal and leaves busy at 0.
- Widths: addresses are unsigned and always in range, since NUM_REGS is a power of two. There is no arithmetic on data.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W_DEF and NUM_REGS_DEF defaults.
  - A reg_addr_t typedef built on ADDR_W.
  - The function for packed-port slicing.
- Natural sub-module: regfile_scoreboard, holding the busy_vec flops, the set/clear priority and the rbusy lookup.
- The data array, write priority and bypass muxes stay in regfile_mp.

Test Plan:
- Reset, then a single write: we_a=1, waddr_a=2, wdata_a=0xAA for one cycle -> raddr0=2 reads 0xAA the next cycle; raddr1=3 reads 0x00.
- Dual write, distinct addresses: A writes R4=0xCC, B writes R5=0x33 in the same cycle -> both read back; wr_conflict stays 0.
- Dual write, same address: A writes R6=0x11, B writes R6=0x22 -> R6 reads 0x11; wr_conflict=1 for exactly one cycle.
- Bypass, BYPASS=1: raddr0=7 while we_b=1, waddr_b=7, wdata_b=0x5A -> rdata0=0x5A in the same cycle. With BYPASS=0, the old value is returned that cycle and 0x5A the next.
- Scoreboard:
  - rsv_en on R3 -> rbusy=1 for raddr=3 from the next cycle.
  - A later A-write to R3 clears it.
  - A reserve and a write to R3 in the same cycle leave it busy.
- Async reset mid-operation and zero register:
  - Drop rst between edges -> all rdata, rbusy and busy_vec read 0 at once.
  - With ZERO_REG=1, writing R0=0xFF -> R0 reads 0x00.
